// File: rtl/cfg_req_gen.sv
// rtl/cfg_req_gen.sv - host-side request initiator for the 134-bit configuration chain
module cfg_req_gen #(
  parameter logic [7:0]  SRC_MID = 8'd1,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic         req_rw,
  input  logic [7:0]   req_dst_mid,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_wdata,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic [31:0]  rsp_rdata,
  output logic         rsp_timeout,
  output logic [133:0] cout_cfg_data,
  output logic         cout_cfg_data_wr,
  input  logic         cin_cfg_ready,
  input  logic [133:0] cin_cfg_data,
  input  logic         cin_cfg_data_wr,
  output logic         cout_cfg_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEAD     = 3'd1,
    TAIL     = 3'd2,
    WAIT_RSP = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          lat_rw;
  logic [7:0]    lat_dst;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic [15:0]   timer;
  logic [133:0]  head_word;
  logic [133:0]  tail_word;
  logic          accept;
  logic          rsp_match;
  logic          rsp_tail;
  logic          timeout_hit;
  logic          unused_cin_bits;

  assign head_word = {2'b01, 4'b0000, 1'b0, (lat_rw ? 3'b010 : 3'b001), 12'h000,
                      SRC_MID, lat_dst, lat_addr, 32'h0000_0000,
                      (lat_rw ? lat_wdata : 32'h0000_0000)};
  assign tail_word = {2'b10, 132'd0};

  assign accept      = (state == IDLE) && req_valid;
  assign timeout_hit = (timer == TIMEOUT - 16'd1);

  // A read response echoes our ID as destination and the target/address we asked for.
  assign rsp_match = cin_cfg_data_wr
                  && (cin_cfg_data[133:132] == 2'b01)
                  && (cin_cfg_data[127:124] == 4'b1011)
                  && (cin_cfg_data[103:96]  == SRC_MID)
                  && (cin_cfg_data[111:104] == lat_dst)
                  && (cin_cfg_data[95:64]   == lat_addr);
  assign rsp_tail  = cin_cfg_data_wr && (cin_cfg_data[133:132] == 2'b10);

  // Header fields this initiator never interprets on the return path.
  assign unused_cin_bits = ^{cin_cfg_data[131:128], cin_cfg_data[123:112], cin_cfg_data[63:32]};

  // Returning words are only observed, so the chain is never stalled.
  assign cout_cfg_ready = 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, response timer and held response results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_rw      <= 1'b0;
      lat_dst     <= 8'h00;
      lat_addr    <= 32'h0000_0000;
      lat_wdata   <= 32'h0000_0000;
      timer       <= 16'h0000;
      rsp_rdata   <= 32'h0000_0000;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        lat_rw      <= req_rw;
        lat_dst     <= req_dst_mid;
        lat_addr    <= req_addr;
        lat_wdata   <= req_wdata;
        rsp_rdata   <= 32'h0000_0000;
        rsp_timeout <= 1'b0;
      end
      if (state == TAIL) begin
        timer <= 16'h0000;
      end else if (state == WAIT_RSP) begin
        timer <= timer + 16'd1;
        // A match on the timeout cycle still counts as a valid response.
        if (rsp_match) begin
          rsp_rdata <= cin_cfg_data[31:0];
        end else if (timeout_hit) begin
          rsp_timeout <= 1'b1;
          rsp_rdata   <= 32'h0000_0000;
        end
      end
    end
  end

  // Next-state and chain/host outputs; words are only driven when the chain accepts them.
  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    rsp_valid        = 1'b0;
    cout_cfg_data    = 134'd0;
    cout_cfg_data_wr = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        if (cin_cfg_ready) begin
          cout_cfg_data    = head_word;
          cout_cfg_data_wr = 1'b1;
          state_nxt        = TAIL;
        end
      end
      TAIL: begin
        if (cin_cfg_ready) begin
          cout_cfg_data    = tail_word;
          cout_cfg_data_wr = 1'b1;
          state_nxt        = lat_rw ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_match) begin
          state_nxt = DRAIN;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DRAIN: begin
        if (rsp_tail) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cfg_req_gen.sv
// tb/tb_cfg_req_gen.sv - directed self-checking bench for cfg_req_gen
module tb_cfg_req_gen;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_rw;
  logic [7:0]   req_dst_mid;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_timeout;
  logic [133:0] cout_cfg_data;
  logic         cout_cfg_data_wr;
  logic         cin_cfg_ready;
  logic [133:0] cin_cfg_data;
  logic         cin_cfg_data_wr;
  logic         cout_cfg_ready;

  int checks   = 0;
  int failures = 0;

  localparam logic [133:0] TAIL_WORD = {2'b10, 132'd0};

  cfg_req_gen #(.SRC_MID(8'd1), .TIMEOUT(16'd16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_rw           (req_rw),
    .req_dst_mid      (req_dst_mid),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .rsp_timeout      (rsp_timeout),
    .cout_cfg_data    (cout_cfg_data),
    .cout_cfg_data_wr (cout_cfg_data_wr),
    .cin_cfg_ready    (cin_cfg_ready),
    .cin_cfg_data     (cin_cfg_data),
    .cin_cfg_data_wr  (cin_cfg_data_wr),
    .cout_cfg_ready   (cout_cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [7:0] dst, input logic [31:0] addr, input logic [31:0] wd);
    req_rw = rw; req_dst_mid = dst; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_dst_mid = 8'h00; req_addr = 32'h0; req_wdata = 32'h0;
    cin_cfg_ready = 1'b1; cin_cfg_data = 134'd0; cin_cfg_data_wr = 1'b0;
    tick; tick; #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp got v=%b t=%b d=%h want 0/0/0", rsp_valid, rsp_timeout, rsp_rdata); end
    checks++; if (cout_cfg_data_wr !== 1'b0 || cout_cfg_data !== 134'd0) begin failures++; $display("FAIL reset_cout got wr=%b d=%h want 0/0", cout_cfg_data_wr, cout_cfg_data); end
    checks++; if (cout_cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cout_ready got=%b want=1", cout_cfg_ready); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_write;
    logic [133:0] exp_head;
    exp_head = {2'b01, 4'h0, 1'b0, 3'b010, 12'h000, 8'd1, 8'd7, 32'h7000_0002, 32'h0, 32'd100};
    cin_cfg_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_idle_ready got=%b want=1", req_ready); end
    issue(1'b1, 8'd7, 32'h7000_0002, 32'd100);
    checks++; if (cout_cfg_data_wr !== 1'b1 || cout_cfg_data !== exp_head) begin failures++; $display("FAIL wr_head got wr=%b d=%h want 1/%h", cout_cfg_data_wr, cout_cfg_data, exp_head); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL wr_busy_ready got=%b want=0", req_ready); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr_rdata_cleared got=%h want=0", rsp_rdata); end
    tick; #1;
    checks++; if (cout_cfg_data_wr !== 1'b1 || cout_cfg_data !== TAIL_WORD) begin failures++; $display("FAIL wr_tail got wr=%b d=%h want 1/%h", cout_cfg_data_wr, cout_cfg_data, TAIL_WORD); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || cout_cfg_data_wr !== 1'b0) begin failures++; $display("FAIL wr_done got v=%b t=%b wr=%b want 1/0/0", rsp_valid, rsp_timeout, cout_cfg_data_wr); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL wr_back_idle got v=%b rdy=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_read;
    logic [133:0] exp_head;
    exp_head = {2'b01, 4'h0, 1'b0, 3'b001, 12'h000, 8'd1, 8'd7, 32'h7000_0003, 32'h0, 32'h0};
    cin_cfg_ready = 1'b1;
    issue(1'b0, 8'd7, 32'h7000_0003, 32'h1234_5678);
    checks++; if (cout_cfg_data_wr !== 1'b1 || cout_cfg_data !== exp_head) begin failures++; $display("FAIL rd_head got wr=%b d=%h want 1/%h", cout_cfg_data_wr, cout_cfg_data, exp_head); end
    tick; #1;
    checks++; if (cout_cfg_data_wr !== 1'b1 || cout_cfg_data !== TAIL_WORD) begin failures++; $display("FAIL rd_tail got wr=%b d=%h want 1/%h", cout_cfg_data_wr, cout_cfg_data, TAIL_WORD); end
    tick; tick;
    checks++; if (cout_cfg_data_wr !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_wait_quiet got wr=%b v=%b want 0/0", cout_cfg_data_wr, rsp_valid); end
    cin_cfg_data = {2'b01, 4'h0, 4'b1011, 12'h000, 8'd7, 8'd1, 32'h7000_0003, 32'h0, 32'h0000_0011};
    cin_cfg_data_wr = 1'b1;
    tick;
    cin_cfg_data = TAIL_WORD;
    tick;
    cin_cfg_data_wr = 1'b0; cin_cfg_data = 134'd0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11 || rsp_timeout !== 1'b0) begin failures++; $display("FAIL rd_done got v=%b d=%h t=%b want 1/00000011/0", rsp_valid, rsp_rdata, rsp_timeout); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h11 || req_ready !== 1'b1) begin failures++; $display("FAIL rd_hold got v=%b d=%h rdy=%b want 0/00000011/1", rsp_valid, rsp_rdata, req_ready); end
  endtask

  task automatic test_backpressure;
    logic         saw_wr;
    logic [133:0] exp_head;
    exp_head = {2'b01, 4'h0, 1'b0, 3'b010, 12'h000, 8'd1, 8'd3, 32'h0000_0030, 32'h0, 32'h0000_0055};
    cin_cfg_ready = 1'b0;
    saw_wr = 1'b0;
    issue(1'b1, 8'd3, 32'h0000_0030, 32'h0000_0055);
    for (int i = 0; i < 5; i++) begin
      if (cout_cfg_data_wr !== 1'b0) saw_wr = 1'b1;
      // A request while busy must not be taken.
      req_valid = (i == 2); req_rw = 1'b0; req_dst_mid = 8'd9; req_addr = 32'hAAAA_0000;
      tick; #1;
    end
    req_valid = 1'b0;
    checks++; if (saw_wr !== 1'b0) begin failures++; $display("FAIL bp_no_wr got=%b want=0", saw_wr); end
    cin_cfg_ready = 1'b1; #1;
    checks++; if (cout_cfg_data_wr !== 1'b1 || cout_cfg_data !== exp_head) begin failures++; $display("FAIL bp_head got wr=%b d=%h want 1/%h", cout_cfg_data_wr, cout_cfg_data, exp_head); end
    tick;
    cin_cfg_ready = 1'b0; #1;
    saw_wr = cout_cfg_data_wr;
    tick; #1;
    if (cout_cfg_data_wr !== 1'b0) saw_wr = 1'b1;
    checks++; if (saw_wr !== 1'b0) begin failures++; $display("FAIL bp_tail_held got=%b want=0", saw_wr); end
    cin_cfg_ready = 1'b1; #1;
    checks++; if (cout_cfg_data_wr !== 1'b1 || cout_cfg_data !== TAIL_WORD) begin failures++; $display("FAIL bp_tail got wr=%b d=%h want 1/%h", cout_cfg_data_wr, cout_cfg_data, TAIL_WORD); end
    tick; #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0) begin failures++; $display("FAIL bp_done got v=%b t=%b want 1/0", rsp_valid, rsp_timeout); end
    tick; #1;
    checks++; if (req_ready !== 1'b1 || cout_cfg_data_wr !== 1'b0) begin failures++; $display("FAIL bp_idle got rdy=%b wr=%b want 1/0", req_ready, cout_cfg_data_wr); end
  endtask

  task automatic test_filter;
    logic seen_valid;
    seen_valid = 1'b0;
    cin_cfg_ready = 1'b1;
    issue(1'b0, 8'd7, 32'h7000_0003, 32'h0);
    tick; tick;
    for (int p = 0; p < 3; p++) begin
      case (p)
        0: cin_cfg_data = {2'b01, 4'h0, 4'b1011, 12'h000, 8'd7, 8'd1, 32'h7000_0008, 32'h0, 32'h0000_0A0A};
        1: cin_cfg_data = {2'b01, 4'h0, 4'b1011, 12'h000, 8'd9, 8'd1, 32'h7000_0003, 32'h0, 32'h0000_0B0B};
        default: cin_cfg_data = {2'b01, 4'h0, 4'b1011, 12'h000, 8'd7, 8'd1, 32'h7000_0003, 32'h0, 32'hDEAD_BEEF};
      endcase
      cin_cfg_data_wr = 1'b1;
      tick;
      cin_cfg_data = TAIL_WORD;
      tick;
      cin_cfg_data_wr = 1'b0; cin_cfg_data = 134'd0;
      #1;
      if (p < 2 && rsp_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_timeout !== 1'b0) begin failures++; $display("FAIL flt_done got v=%b d=%h t=%b want 1/deadbeef/0", rsp_valid, rsp_rdata, rsp_timeout); end
    checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL flt_foreign_ignored got=%b want=0", seen_valid); end
    tick;
  endtask

  task automatic test_timeout;
    int k;
    int got;
    got = -1;
    cin_cfg_ready = 1'b1;
    issue(1'b0, 8'd5, 32'h5000_0001, 32'h0);
    tick; #1;
    checks++; if (cout_cfg_data !== TAIL_WORD) begin failures++; $display("FAIL to_tail got d=%h want %h", cout_cfg_data, TAIL_WORD); end
    for (k = 1; k <= 40; k++) begin
      tick; #1;
      if (rsp_valid === 1'b1) begin
        got = k;
        break;
      end
    end
    // Tail cycle, then 16 cycles in WAIT_RSP, then DONE.
    checks++; if (got != 17) begin failures++; $display("FAIL to_latency got=%0d want=17", got); end
    checks++; if (rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_flags got t=%b d=%h want 1/0", rsp_timeout, rsp_rdata); end
    tick; #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b1) begin failures++; $display("FAIL to_idle got rdy=%b v=%b t=%b want 1/0/1", req_ready, rsp_valid, rsp_timeout); end
  endtask

  task automatic test_reset_mid;
    logic stale;
    stale = 1'b0;
    cin_cfg_ready = 1'b1;
    issue(1'b0, 8'd7, 32'h7000_0003, 32'h0);
    tick; tick; tick;
    rst_n = 1'b0; #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_mid_host got rdy=%b v=%b t=%b d=%h want 1/0/0/0", req_ready, rsp_valid, rsp_timeout, rsp_rdata); end
    checks++; if (cout_cfg_data_wr !== 1'b0 || cout_cfg_data !== 134'd0) begin failures++; $display("FAIL rst_mid_chain got wr=%b d=%h want 0/0", cout_cfg_data_wr, cout_cfg_data); end
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick; #1;
      if (rsp_valid !== 1'b0 || cout_cfg_data_wr !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rst_mid_stale got=%b want=0", stale); end
    test_write;
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_backpressure;
    test_filter;
    test_timeout;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
